csr_unit: RTL and testbench
===========================

# csr_unit

Parametrised machine-mode CSR block for the pipelined RV32 core, replacing the single-register tohost write in the datapath. Executes all six Zicsr operations in the Execute stage against a bank of scratch CSRs, free-running cycle/instret counters and a tohost mailbox with host handshake. Returns the old CSR value for writeback and stalls the pipeline while a previous tohost message is still unacknowledged.

## Interface
- XLEN, 32: data width.
- NUM_SCRATCH, 4: read/write scratch CSRs at 0x7C0 .. 0x7C0+NUM_SCRATCH-1; range 1..16.
- CNT_WIDTH, 64: cycle/instret counter width; range XLEN..2*XLEN.
- TOHOST_ADDR, 12'h51E: tohost CSR address.

- clk  in  1  clock; all state updates on rising edge.
- n_rst  in  1  asynchronous active-low reset.
- csr_en  in  1  valid CSR instruction in E stage (already flush-qualified).
- funct3  in  3  Zicsr operation.
- csr_addr  in  12  CSR address (instr[31:20]).
- rs1_idx  in  5  rs1 field; also the zero-extended uimm for *I forms.
- rs1_data  in  XLEN  forwarded rs1 value.
- retire  in  1  one instruction retires this cycle.
- tohost_ack  in  1  host consumed the tohost message.
- csr_rdata  out  XLEN  old CSR value, combinational.
- csr_illegal  out  1  illegal CSR access, combinational.
- csr_stall  out  1  stall F/D/E, combinational.
- tohost_valid  out  1  message pending.
- tohost_data  out  XLEN  pending message.

## Operation
- funct3: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI; 000/100 illegal.
- Source operand: rs1_data for 001–011; {zeros, rs1_idx} for 101–111.
- New value: RW = src; RS = old | src; RC = old & ~src.
- Write attempted: RW/RWI always; RS/RC/RSI/RCI only when rs1_idx != 0.
- Map: scratch bank (RW); TOHOST_ADDR (RW); 0xC00 cycle low, 0xC02 instret low (RO); 0xC80/0xC82 counter bits [CNT_WIDTH-1:XLEN], zero-extended (RO, present only when CNT_WIDTH > XLEN).
- csr_illegal = csr_en & (bad funct3 | unmapped address | write attempted to RO address). Illegal access: no state change, csr_rdata = 0.
- csr_rdata = 0 when csr_en = 0.
- Counters: cycle increments every cycle; instret increments when retire = 1; both wrap 2^CNT_WIDTH-1 -> 0.
- tohost FSM, states IDLE, PENDING:
  - IDLE, committed write of value v: tohost_data <= v; v != 0 -> PENDING; v == 0 -> stay IDLE.
  - PENDING, tohost_ack = 1 -> IDLE, tohost_data <= 0.
  - tohost_ack in IDLE is ignored.
  - Reads of tohost return tohost_data in either state.
- tohost_valid = (state == PENDING).
- csr_stall = csr_en & (csr_addr == TOHOST_ADDR) & write attempted & state == PENDING. A stalled write is not committed and retries while the stall holds. When ack coincides with the stalled write, the write commits on the following cycle.

## Timing
- Reset: all scratch, counters, tohost_data = 0; FSM IDLE; tohost_valid = 0. Combinational outputs follow from reset state: csr_stall = 0, csr_rdata = 0, csr_illegal = 0 with csr_en = 0.
- Read latency 0: csr_rdata is the pre-edge value; a write lands on the same edge and is visible the next cycle.
- A counter read returns the value before this cycle's increment.
- Reset asserted mid-PENDING drops tohost_valid immediately (asynchronous).
- Back-to-back CSR writes to the same address each see the prior cycle's result; no internal forwarding required.

## Structure
- Package csr_pkg: address constants (CSR_CYCLE, CSR_INSTRET, CSR_CYCLEH, CSR_INSTRETH, CSR_SCRATCH_BASE); funct3 enum csr_op_e; FSM typedef tohost_state_e.
- Sub-module csr_counter (WIDTH, enable, wrap): instantiated for cycle and instret.
- Remainder in csr_unit: decode, operand mux, scratch array, tohost FSM.

## Test plan
- Reset release, 10 idle cycles, then CSRRS x0 read of 0xC00 -> csr_rdata = 10, no write, csr_illegal = 0.
- CSRRW 0x7C1 with rs1_data = 0xA5A5_0000, then CSRRSI 0x7C1 uimm = 5, then CSRRC rs1_data = 0xA500_0000 -> rdata sequence 0, 0xA5A5_0000, 0xA5A5_0005; final value 0x00A5_0005.
- CSRRWI 0xC00 uimm = 1 -> csr_illegal = 1, cycle counter unchanged; funct3 = 000 -> illegal; unmapped address 0x7FF -> illegal.
- CSRRW tohost = 1 -> tohost_valid = 1 next cycle. Second write of 3 -> csr_stall = 1 until ack; 3 is committed the cycle after the ack cycle.
- Preload instret = 2^64-2 through a force hook; two retire pulses -> 0xC02 and 0xC82 read 0.
- Assert n_rst during PENDING -> tohost_valid = 0 and tohost_data = 0 without a clock edge.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared constants and types for the machine-mode CSR block.
package csr_pkg;
    localparam logic [11:0] CSR_CYCLE        = 12'hC00;
    localparam logic [11:0] CSR_INSTRET      = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH       = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH     = 12'hC82;
    localparam logic [11:0] CSR_SCRATCH_BASE = 12'h7C0;

    typedef enum logic [2:0] {
        OP_RW  = 3'b001,
        OP_RS  = 3'b010,
        OP_RC  = 3'b011,
        OP_RWI = 3'b101,
        OP_RSI = 3'b110,
        OP_RCI = 3'b111
    } csr_op_e;

    typedef enum logic {
        TH_IDLE    = 1'b0,
        TH_PENDING = 1'b1
    } tohost_state_e;
endpackage

// File: rtl/csr_counter.sv
// Free-running wrap-around counter with an enable and a preload port.
module csr_counter #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             i_en,
    input  logic             i_ld,
    input  logic [WIDTH-1:0] i_ld_val,
    output logic [WIDTH-1:0] o_count
);
    logic [WIDTH-1:0] r_count;

    // Preload wins over increment; overflow wraps naturally to zero.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)     r_count <= '0;
        else if (i_ld)  r_count <= i_ld_val;
        else if (i_en)  r_count <= r_count + WIDTH'(1);
    end

    assign o_count = r_count;
endmodule

// File: rtl/csr_unit.sv
// Zicsr execute-stage unit: scratch CSRs, cycle/instret counters and a
// tohost mailbox that stalls the pipeline while a message is unacknowledged.
module csr_unit
    import csr_pkg::*;
#(
    parameter int          XLEN        = 32,
    parameter int          NUM_SCRATCH = 4,
    parameter int          CNT_WIDTH   = 64,
    parameter logic [11:0] TOHOST_ADDR = 12'h51E
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic            csr_en,
    input  logic [2:0]      funct3,
    input  logic [11:0]     csr_addr,
    input  logic [4:0]      rs1_idx,
    input  logic [XLEN-1:0] rs1_data,
    input  logic            retire,
    input  logic            tohost_ack,
    output logic [XLEN-1:0] csr_rdata,
    output logic            csr_illegal,
    output logic            csr_stall,
    output logic            tohost_valid,
    output logic [XLEN-1:0] tohost_data
);
    localparam bit HAS_HI = CNT_WIDTH > XLEN;

    logic [CNT_WIDTH-1:0] w_cycle, w_instret;
    logic [2*XLEN-1:0]    w_cycle_ext, w_instret_ext;
    // Preload hook for instret; tied off in the design, overridable from a bench.
    logic                 w_instret_ld;
    logic [CNT_WIDTH-1:0] w_instret_ld_val;

    assign w_instret_ld     = 1'b0;
    assign w_instret_ld_val = '0;

    csr_counter #(.WIDTH(CNT_WIDTH)) u_cycle (
        .clk(clk), .n_rst(n_rst), .i_en(1'b1), .i_ld(1'b0), .i_ld_val('0), .o_count(w_cycle)
    );
    csr_counter #(.WIDTH(CNT_WIDTH)) u_instret (
        .clk(clk), .n_rst(n_rst), .i_en(retire), .i_ld(w_instret_ld),
        .i_ld_val(w_instret_ld_val), .o_count(w_instret)
    );

    assign w_cycle_ext   = (2*XLEN)'(w_cycle);
    assign w_instret_ext = (2*XLEN)'(w_instret);

    logic [NUM_SCRATCH-1:0][XLEN-1:0] r_scratch;
    tohost_state_e   r_th_state, w_th_state_nxt;
    logic [XLEN-1:0] r_th_data, w_th_data_nxt;

    logic            w_bad_f3, w_wr_try, w_is_scratch, w_is_tohost;
    logic            w_mapped, w_ro, w_illegal, w_stall, w_commit;
    logic [3:0]      w_scr_idx;
    logic [XLEN-1:0] w_src, w_old, w_new;

    assign w_bad_f3     = (funct3[1:0] == 2'b00);
    assign w_src        = funct3[2] ? XLEN'(rs1_idx) : rs1_data;
    // RW/RWI always write; set/clear forms only with a nonzero rs1/uimm field.
    assign w_wr_try     = (funct3[1:0] == 2'b01) || (rs1_idx != 5'd0);
    assign w_scr_idx    = csr_addr[3:0];
    assign w_is_scratch = (csr_addr[11:4] == CSR_SCRATCH_BASE[11:4]) &&
                          ({1'b0, w_scr_idx} < 5'(NUM_SCRATCH));
    assign w_is_tohost  = (csr_addr == TOHOST_ADDR);

    always_comb begin
        w_old    = '0;
        w_mapped = 1'b1;
        w_ro     = 1'b1;
        if (w_is_scratch) begin
            w_ro = 1'b0;
            for (int i = 0; i < NUM_SCRATCH; i++)
                if (w_scr_idx == 4'(i)) w_old = r_scratch[i];
        end else if (w_is_tohost) begin
            w_ro  = 1'b0;
            w_old = r_th_data;
        end else begin
            case (csr_addr)
                CSR_CYCLE:    w_old = w_cycle_ext[XLEN-1:0];
                CSR_INSTRET:  w_old = w_instret_ext[XLEN-1:0];
                CSR_CYCLEH:   if (HAS_HI) w_old = w_cycle_ext[2*XLEN-1:XLEN];   else w_mapped = 1'b0;
                CSR_INSTRETH: if (HAS_HI) w_old = w_instret_ext[2*XLEN-1:XLEN]; else w_mapped = 1'b0;
                default:      w_mapped = 1'b0;
            endcase
        end
    end

    always_comb begin
        case (funct3[1:0])
            2'b10:   w_new = w_old | w_src;
            2'b11:   w_new = w_old & ~w_src;
            default: w_new = w_src;
        endcase
    end

    assign w_illegal = csr_en & (w_bad_f3 | ~w_mapped | (w_wr_try & w_ro));
    assign w_stall   = csr_en & w_is_tohost & w_wr_try & (r_th_state == TH_PENDING);
    assign w_commit  = csr_en & ~w_illegal & w_wr_try & ~w_stall;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_scratch <= '0;
        end else if (w_commit && w_is_scratch) begin
            for (int i = 0; i < NUM_SCRATCH; i++)
                if (w_scr_idx == 4'(i)) r_scratch[i] <= w_new;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_th_state <= TH_IDLE;
            r_th_data  <= '0;
        end else begin
            r_th_state <= w_th_state_nxt;
            r_th_data  <= w_th_data_nxt;
        end
    end

    // A write while PENDING is stalled, so commits only ever arrive in IDLE.
    always_comb begin
        w_th_state_nxt = r_th_state;
        w_th_data_nxt  = r_th_data;
        case (r_th_state)
            TH_IDLE: begin
                if (w_commit && w_is_tohost) begin
                    w_th_data_nxt = w_new;
                    if (w_new != '0) w_th_state_nxt = TH_PENDING;
                end
            end
            TH_PENDING: begin
                if (tohost_ack) begin
                    w_th_state_nxt = TH_IDLE;
                    w_th_data_nxt  = '0;
                end
            end
            default: w_th_state_nxt = TH_IDLE;
        endcase
    end

    assign csr_rdata    = (csr_en && !w_illegal) ? w_old : '0;
    assign csr_illegal  = w_illegal;
    assign csr_stall    = w_stall;
    assign tohost_valid = (r_th_state == TH_PENDING);
    assign tohost_data  = r_th_data;
endmodule

// File: tb/tb_csr_unit.sv
// Directed bench for csr_unit: table of single-cycle CSR accesses plus
// hand sequences for counters, the tohost handshake and async reset.
module tb_csr_unit;
    logic        clk = 1'b0;
    logic        n_rst;
    logic        csr_en;
    logic [2:0]  funct3;
    logic [11:0] csr_addr;
    logic [4:0]  rs1_idx;
    logic [31:0] rs1_data;
    logic        retire;
    logic        tohost_ack;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        csr_stall;
    logic        tohost_valid;
    logic [31:0] tohost_data;

    int n_checks = 0;
    int n_errors = 0;
    logic [63:0] tb_cyc;

    csr_unit #(.XLEN(32), .NUM_SCRATCH(4), .CNT_WIDTH(64), .TOHOST_ADDR(12'h51E)) dut (
        .clk(clk), .n_rst(n_rst), .csr_en(csr_en), .funct3(funct3), .csr_addr(csr_addr),
        .rs1_idx(rs1_idx), .rs1_data(rs1_data), .retire(retire), .tohost_ack(tohost_ack),
        .csr_rdata(csr_rdata), .csr_illegal(csr_illegal), .csr_stall(csr_stall),
        .tohost_valid(tohost_valid), .tohost_data(tohost_data)
    );

    always #5 clk = ~clk;

    // Reference count of clock edges since reset release.
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) tb_cyc <= 64'd0;
        else        tb_cyc <= tb_cyc + 64'd1;
    end

    typedef struct {
        logic        en;
        logic [2:0]  f3;
        logic [11:0] addr;
        logic [4:0]  idx;
        logic [31:0] data;
        logic [31:0] exp_rd;
        logic        exp_ill;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic [2:0] f3, input logic [11:0] addr,
                         input logic [4:0] idx, input logic [31:0] data);
        csr_en   = en;
        funct3   = f3;
        csr_addr = addr;
        rs1_idx  = idx;
        rs1_data = data;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 3'b001, 12'h7C1, 5'd1, 32'hA5A5_0000, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b1, 3'b110, 12'h7C1, 5'd5, 32'h0000_0000, 32'hA5A5_0000, 1'b0};
        vecs[2]  = '{1'b1, 3'b011, 12'h7C1, 5'd2, 32'hA500_0000, 32'hA5A5_0005, 1'b0};
        vecs[3]  = '{1'b1, 3'b010, 12'h7C1, 5'd0, 32'hFFFF_FFFF, 32'h00A5_0005, 1'b0};
        vecs[4]  = '{1'b1, 3'b001, 12'h7C0, 5'd3, 32'h1234_5678, 32'h0000_0000, 1'b0};
        vecs[5]  = '{1'b1, 3'b111, 12'h7C0, 5'h18, 32'h0000_0000, 32'h1234_5678, 1'b0};
        vecs[6]  = '{1'b1, 3'b010, 12'h7C0, 5'd0, 32'h0000_0000, 32'h1234_5660, 1'b0};
        vecs[7]  = '{1'b1, 3'b001, 12'h7C3, 5'd4, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
        vecs[8]  = '{1'b1, 3'b001, 12'h7C4, 5'd4, 32'h1111_1111, 32'h0000_0000, 1'b1};
        vecs[9]  = '{1'b1, 3'b000, 12'h7C1, 5'd3, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
        vecs[10] = '{1'b1, 3'b100, 12'h7C1, 5'd3, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
        vecs[11] = '{1'b1, 3'b010, 12'h7FF, 5'd0, 32'h0000_0000, 32'h0000_0000, 1'b1};
        vecs[12] = '{1'b1, 3'b101, 12'hC02, 5'd1, 32'h0000_0000, 32'h0000_0000, 1'b1};
        vecs[13] = '{1'b1, 3'b010, 12'hC82, 5'd0, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[14] = '{1'b1, 3'b110, 12'hC02, 5'd0, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[15] = '{1'b0, 3'b010, 12'h7C3, 5'd0, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[16] = '{1'b1, 3'b010, 12'h7C3, 5'd0, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};
        vecs[17] = '{1'b1, 3'b010, 12'h7C1, 5'd0, 32'h0000_0000, 32'h00A5_0005, 1'b0};

        n_rst = 1'b0; retire = 1'b0; tohost_ack = 1'b0;
        drive(1'b0, 3'b000, 12'h000, 5'd0, 32'h0);
        repeat (2) @(negedge clk);
        chk("reset_rdata",  csr_rdata,           32'h0);
        chk("reset_ill",    32'(csr_illegal),    32'h0);
        chk("reset_stall",  32'(csr_stall),      32'h0);
        chk("reset_valid",  32'(tohost_valid),   32'h0);
        chk("reset_thdata", tohost_data,         32'h0);
        n_rst = 1'b1;

        // Cycle counter after ten edges, read with CSRRS x0 (no write).
        repeat (10) @(posedge clk);
        @(negedge clk);
        drive(1'b1, 3'b010, 12'hC00, 5'd0, 32'h0);
        #1;
        chk("cycle_after_10", csr_rdata, 32'd10);
        chk("cycle_read_ill", 32'(csr_illegal), 32'h0);

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            drive(vecs[i].en, vecs[i].f3, vecs[i].addr, vecs[i].idx, vecs[i].data);
            #1;
            chk($sformatf("vec%0d_rdata", i), csr_rdata, vecs[i].exp_rd);
            chk($sformatf("vec%0d_ill", i), 32'(csr_illegal), 32'(vecs[i].exp_ill));
            chk($sformatf("vec%0d_stall", i), 32'(csr_stall), 32'h0);
        end

        // Illegal write to cycle leaves it counting from the model value.
        @(negedge clk); drive(1'b1, 3'b010, 12'hC00, 5'd0, 32'h0); #1;
        chk("cyc_pre", csr_rdata, tb_cyc[31:0]);
        @(negedge clk); drive(1'b1, 3'b101, 12'hC00, 5'd1, 32'h0); #1;
        chk("cyc_wr_ill", 32'(csr_illegal), 32'h1);
        chk("cyc_wr_rd0", csr_rdata, 32'h0);
        @(negedge clk); drive(1'b1, 3'b010, 12'hC00, 5'd0, 32'h0); #1;
        chk("cyc_post", csr_rdata, tb_cyc[31:0]);
        @(negedge clk); drive(1'b1, 3'b010, 12'hC80, 5'd0, 32'h0); #1;
        chk("cych_post", csr_rdata, tb_cyc[63:32]);

        // tohost handshake.
        @(negedge clk); drive(1'b1, 3'b001, 12'h51E, 5'd1, 32'd1); #1;
        chk("th1_stall", 32'(csr_stall), 32'h0);
        chk("th1_valid", 32'(tohost_valid), 32'h0);
        @(negedge clk); drive(1'b1, 3'b010, 12'h51E, 5'd0, 32'h0); #1;
        chk("th_rd_valid", 32'(tohost_valid), 32'h1);
        chk("th_rd_stall", 32'(csr_stall), 32'h0);
        chk("th_rd_data", csr_rdata, 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); drive(1'b1, 3'b001, 12'h51E, 5'd1, 32'd3);
            tohost_ack = (k == 2); #1;
            chk($sformatf("th3_stall%0d", k), 32'(csr_stall), 32'h1);
            chk($sformatf("th3_valid%0d", k), 32'(tohost_valid), 32'h1);
            chk($sformatf("th3_rd%0d", k), csr_rdata, 32'd1);
        end
        @(negedge clk); tohost_ack = 1'b0; #1;
        chk("th3_retry_stall", 32'(csr_stall), 32'h0);
        chk("th3_retry_valid", 32'(tohost_valid), 32'h0);
        chk("th3_retry_rd", csr_rdata, 32'h0);
        @(negedge clk); drive(1'b0, 3'b000, 12'h000, 5'd0, 32'h0); #1;
        chk("th3_valid", 32'(tohost_valid), 32'h1);
        chk("th3_data", tohost_data, 32'd3);
        @(negedge clk); tohost_ack = 1'b1;
        @(negedge clk); #1;
        chk("th_ack_valid", 32'(tohost_valid), 32'h0);
        chk("th_ack_data", tohost_data, 32'h0);
        @(negedge clk); #1;
        chk("th_idle_ack", 32'(tohost_valid), 32'h0);
        tohost_ack = 1'b0;
        @(negedge clk); drive(1'b1, 3'b001, 12'h51E, 5'd1, 32'd0); #1;
        chk("th0_stall", 32'(csr_stall), 32'h0);
        @(negedge clk); drive(1'b0, 3'b000, 12'h000, 5'd0, 32'h0); #1;
        chk("th0_valid", 32'(tohost_valid), 32'h0);

        // instret wrap from 2^64-2 after two retires.
        force dut.w_instret_ld = 1'b1;
        force dut.w_instret_ld_val = 64'hFFFF_FFFF_FFFF_FFFE;
        @(posedge clk);
        @(negedge clk);
        release dut.w_instret_ld;
        release dut.w_instret_ld_val;
        drive(1'b1, 3'b010, 12'hC02, 5'd0, 32'h0); #1;
        chk("instret_pre_lo", csr_rdata, 32'hFFFF_FFFE);
        @(negedge clk); drive(1'b1, 3'b010, 12'hC82, 5'd0, 32'h0); retire = 1'b1; #1;
        chk("instret_pre_hi", csr_rdata, 32'hFFFF_FFFF);
        @(negedge clk);
        @(negedge clk); retire = 1'b0; drive(1'b1, 3'b010, 12'hC02, 5'd0, 32'h0); #1;
        chk("instret_wrap_lo", csr_rdata, 32'h0);
        @(negedge clk); drive(1'b1, 3'b010, 12'hC82, 5'd0, 32'h0); #1;
        chk("instret_wrap_hi", csr_rdata, 32'h0);

        // Asynchronous reset during PENDING.
        @(negedge clk); drive(1'b1, 3'b001, 12'h51E, 5'd1, 32'd7);
        @(negedge clk); drive(1'b0, 3'b000, 12'h000, 5'd0, 32'h0); #1;
        chk("rst_pend_valid", 32'(tohost_valid), 32'h1);
        #1 n_rst = 1'b0;
        #1;
        chk("rst_async_valid", 32'(tohost_valid), 32'h0);
        chk("rst_async_data", tohost_data, 32'h0);
        @(negedge clk); n_rst = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
